mem_req_arbiter: RTL and testbench

//  Round-robin arbiter that shares one native-style memory port (valid/ready, addr, wdata, wstrb, rdata)

---
 rtl/mem_req_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_req_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one native valid/ready memory port between NREQ requesters.
// One transaction in flight: IDLE -> ACCESS -> RESP -> IDLE, with an optional ACCESS watchdog.
module mem_req_arbiter #(
    parameter int unsigned NREQ     = 2,
    parameter int unsigned TIMEOUT  = 0,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ*32-1:0]   req_addr_i,
    input  logic [NREQ*32-1:0]   req_wdata_i,
    input  logic [NREQ*4-1:0]    req_wstrb_i,
    output logic [31:0]          req_rdata_o,
    output logic                 mem_valid_o,
    input  logic                 mem_ready_i,
    output logic [31:0]          mem_addr_o,
    output logic [31:0]          mem_wdata_o,
    output logic [3:0]           mem_wstrb_o,
    input  logic [31:0]          mem_rdata_i,
    output logic [NREQ-1:0]      grant_o,
    output logic                 timeout_err_o
);

    localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned WDW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t              state_q;
    logic [NREQ-1:0]     grant_q;
    logic [IDXW-1:0]     last_grant_q;
    logic                mem_valid_q;
    logic [31:0]         mem_addr_q;
    logic [31:0]         mem_wdata_q;
    logic [3:0]          mem_wstrb_q;
    logic [NREQ-1:0]     req_ready_q;
    logic [31:0]         req_rdata_q;
    logic                timeout_err_q;
    logic [WDW-1:0]      wdog_q;

    logic                pick_found_c;
    logic [IDXW-1:0]     pick_idx_c;
    logic [31:0]         pick_addr_c;
    logic [31:0]         pick_wdata_c;
    logic [3:0]          pick_wstrb_c;
    logic                wdog_expired_c;

    // Round-robin pick: first valid above last_grant, else wrap to the lowest valid index.
    always_comb begin
        pick_found_c = 1'b0;
        pick_idx_c   = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!pick_found_c && req_valid_i[i] && (IDXW'(i) > last_grant_q)) begin
                pick_found_c = 1'b1;
                pick_idx_c   = IDXW'(i);
            end
        end
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!pick_found_c && req_valid_i[i] && (IDXW'(i) <= last_grant_q)) begin
                pick_found_c = 1'b1;
                pick_idx_c   = IDXW'(i);
            end
        end
    end

    // Select the payload slice of the picked requester.
    always_comb begin
        pick_addr_c  = '0;
        pick_wdata_c = '0;
        pick_wstrb_c = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (IDXW'(i) == pick_idx_c) begin
                pick_addr_c  = req_addr_i[32*i +: 32];
                pick_wdata_c = req_wdata_i[32*i +: 32];
                pick_wstrb_c = req_wstrb_i[4*i +: 4];
            end
        end
    end

    // Watchdog fires at the end of ACCESS cycle TIMEOUT; disabled when TIMEOUT is zero.
    always_comb begin
        wdog_expired_c = (TIMEOUT > 0) && (wdog_q == WDW'(TIMEOUT - 1));
    end

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            grant_q       <= '0;
            last_grant_q  <= IDXW'(NREQ - 1);
            mem_valid_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_wstrb_q   <= '0;
            req_ready_q   <= '0;
            req_rdata_q   <= '0;
            timeout_err_q <= 1'b0;
            wdog_q        <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (pick_found_c) begin
                        mem_addr_q   <= pick_addr_c;
                        mem_wdata_q  <= pick_wdata_c;
                        mem_wstrb_q  <= pick_wstrb_c;
                        grant_q      <= NREQ'(1) << pick_idx_c;
                        last_grant_q <= pick_idx_c;
                        mem_valid_q  <= 1'b1;
                        wdog_q       <= '0;
                        state_q      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (mem_ready_i) begin
                        req_rdata_q <= mem_rdata_i;
                        mem_valid_q <= 1'b0;
                        req_ready_q <= grant_q;
                        state_q     <= S_RESP;
                    end else if (wdog_expired_c) begin
                        req_rdata_q   <= ERR_DATA;
                        mem_valid_q   <= 1'b0;
                        req_ready_q   <= grant_q;
                        timeout_err_q <= 1'b1;
                        state_q       <= S_RESP;
                    end else begin
                        wdog_q <= wdog_q + WDW'(1);
                    end
                end
                S_RESP: begin
                    req_ready_q   <= '0;
                    grant_q       <= '0;
                    timeout_err_q <= 1'b0;
                    state_q       <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o   = req_ready_q;
    assign req_rdata_o   = req_rdata_q;
    assign mem_valid_o   = mem_valid_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wdata_o   = mem_wdata_q;
    assign mem_wstrb_o   = mem_wstrb_q;
    assign grant_o       = grant_q;
    assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: a 2-requester instance with an 8-cycle watchdog
// and a 4-requester instance for wrap-around arbitration.
`timescale 1ns/1ps
module tb_mem_req_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    // 2-requester instance
    logic [1:0]  v2;
    logic [1:0]  rdy2;
    logic [63:0] addr2;
    logic [63:0] wdata2;
    logic [7:0]  wstrb2;
    logic [31:0] rdata2;
    logic        mv2;
    logic        mr2;
    logic [31:0] ma2;
    logic [31:0] mwd2;
    logic [3:0]  mws2;
    logic [31:0] mrd2;
    logic [1:0]  g2;
    logic        terr2;

    // 4-requester instance
    logic [3:0]   v4;
    logic [3:0]   rdy4;
    logic [127:0] addr4;
    logic [127:0] wdata4;
    logic [15:0]  wstrb4;
    logic [31:0]  rdata4;
    logic         mv4;
    logic         mr4;
    logic [31:0]  ma4;
    logic [31:0]  mwd4;
    logic [3:0]   mws4;
    logic [31:0]  mrd4;
    logic [3:0]   g4;
    logic         terr4;

    logic [1:0]  exp_g [4];
    logic [31:0] exp_a;

    mem_req_arbiter #(.NREQ(2), .TIMEOUT(8), .ERR_DATA(32'hDEAD_BEEF)) u_dut (
        .clk_i(clk), .reset_i(reset),
        .req_valid_i(v2), .req_ready_o(rdy2),
        .req_addr_i(addr2), .req_wdata_i(wdata2), .req_wstrb_i(wstrb2),
        .req_rdata_o(rdata2),
        .mem_valid_o(mv2), .mem_ready_i(mr2),
        .mem_addr_o(ma2), .mem_wdata_o(mwd2), .mem_wstrb_o(mws2),
        .mem_rdata_i(mrd2),
        .grant_o(g2), .timeout_err_o(terr2)
    );

    mem_req_arbiter #(.NREQ(4), .TIMEOUT(0), .ERR_DATA(32'hDEAD_BEEF)) u_dut4 (
        .clk_i(clk), .reset_i(reset),
        .req_valid_i(v4), .req_ready_o(rdy4),
        .req_addr_i(addr4), .req_wdata_i(wdata4), .req_wstrb_i(wstrb4),
        .req_rdata_o(rdata4),
        .mem_valid_o(mv4), .mem_ready_i(mr4),
        .mem_addr_o(ma4), .mem_wdata_o(mwd4), .mem_wstrb_o(mws4),
        .mem_rdata_i(mrd4),
        .grant_o(g4), .timeout_err_o(terr4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and let registered outputs settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset  = 1'b1;
        v2 = '0; addr2 = '0; wdata2 = '0; wstrb2 = '0; mr2 = 1'b0; mrd2 = '0;
        v4 = '0; addr4 = '0; wdata4 = '0; wstrb4 = '0; mr4 = 1'b0; mrd4 = '0;
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
        step();
        step();

        // Reset state
        chk("rst_grant",    32'(g2),    32'h0);
        chk("rst_mem_valid",32'(mv2),   32'h0);
        chk("rst_req_ready",32'(rdy2),  32'h0);
        chk("rst_terr",     32'(terr2), 32'h0);
        chk("rst_mem_addr", ma2,        32'h0);
        chk("rst_rdata",    rdata2,     32'h0);
        reset = 1'b0;

        // 1: requester 0 reads 0x100, memory answers in the second ACCESS cycle
        v2 = 2'b01;
        addr2[31:0] = 32'h0000_0100;
        step();
        chk("t1_grant",     32'(g2),   32'h1);
        chk("t1_mem_valid", 32'(mv2),  32'h1);
        chk("t1_mem_addr",  ma2,       32'h0000_0100);
        chk("t1_mem_wstrb", 32'(mws2), 32'h0);
        chk("t1_ready_early",32'(rdy2),32'h0);
        step();
        chk("t1_mem_valid_hold", 32'(mv2), 32'h1);
        mr2 = 1'b1;
        mrd2 = 32'h1234_5678;
        step();
        mr2 = 1'b0;
        mrd2 = 32'h0;
        v2 = 2'b00;
        chk("t1_ready",       32'(rdy2), 32'h1);
        chk("t1_rdata",       rdata2,    32'h1234_5678);
        chk("t1_mem_valid_off",32'(mv2), 32'h0);
        step();
        chk("t1_ready_once",  32'(rdy2), 32'h0);
        chk("t1_grant_clear", 32'(g2),   32'h0);

        // 2: both requesters always valid after reset -> 0,1,0,1
        reset = 1'b1;
        step();
        reset = 1'b0;
        v2 = 2'b11;
        addr2 = {32'h0000_2000, 32'h0000_1000};
        for (int t = 0; t < 4; t++) begin
            exp_a = (exp_g[t] == 2'b01) ? 32'h0000_1000 : 32'h0000_2000;
            step();
            chk("t2_grant", 32'(g2), 32'(exp_g[t]));
            chk("t2_addr",  ma2,     exp_a);
            mr2 = 1'b1;
            step();
            mr2 = 1'b0;
            chk("t2_ready", 32'(rdy2), 32'(exp_g[t]));
            step();
            chk("t2_idle_grant", 32'(g2), 32'h0);
        end
        v2 = 2'b00;

        // 3: requester 1 writes 0xCAFEF00D with wstrb 0011 to 0x200; payload stays frozen
        v2 = 2'b10;
        addr2[63:32]  = 32'h0000_0200;
        wdata2[63:32] = 32'hCAFE_F00D;
        wstrb2[7:4]   = 4'b0011;
        step();
        chk("t3_grant", 32'(g2), 32'h2);
        addr2[63:32]  = 32'h0000_03FC;
        wdata2[63:32] = 32'h0;
        wstrb2[7:4]   = 4'b1111;
        for (int t = 0; t < 3; t++) begin
            chk("t3_addr",  ma2,       32'h0000_0200);
            chk("t3_wdata", mwd2,      32'hCAFE_F00D);
            chk("t3_wstrb", 32'(mws2), 32'h3);
            step();
        end
        mr2 = 1'b1;
        step();
        mr2 = 1'b0;
        v2 = 2'b00;
        wstrb2 = '0;
        chk("t3_ready", 32'(rdy2), 32'h2);
        step();
        chk("t3_ready_once", 32'(rdy2), 32'h0);

        // 4: watchdog abort after 8 ACCESS cycles, then normal service
        v2 = 2'b01;
        addr2[31:0] = 32'h0000_0800;
        step();
        chk("t4_grant", 32'(g2), 32'h1);
        for (int t = 0; t < 7; t++) begin
            step();
            chk("t4_no_terr",  32'(terr2), 32'h0);
            chk("t4_mv_held",  32'(mv2),   32'h1);
        end
        step();
        chk("t4_terr",      32'(terr2), 32'h1);
        chk("t4_ready",     32'(rdy2),  32'h1);
        chk("t4_rdata",     rdata2,     32'hDEAD_BEEF);
        chk("t4_mv_off",    32'(mv2),   32'h0);
        v2 = 2'b00;
        mr2 = 1'b1;
        step();
        chk("t4_terr_once", 32'(terr2), 32'h0);
        chk("t4_ready_once",32'(rdy2),  32'h0);
        step();
        chk("t4_late_ignored", 32'(mv2), 32'h0);
        mr2 = 1'b0;
        v2 = 2'b10;
        addr2[63:32] = 32'h0000_0440;
        step();
        chk("t4_next_grant", 32'(g2), 32'h2);
        chk("t4_next_addr",  ma2,     32'h0000_0440);
        mr2 = 1'b1;
        mrd2 = 32'h0BAD_F00D;
        step();
        mr2 = 1'b0;
        v2 = 2'b00;
        chk("t4_next_ready", 32'(rdy2),  32'h2);
        chk("t4_next_rdata", rdata2,     32'h0BAD_F00D);
        chk("t4_next_terr",  32'(terr2), 32'h0);
        step();

        // 5: reset during ACCESS clears everything; next arbitration starts at requester 0
        v2 = 2'b10;
        step();
        chk("t5_grant",     32'(g2), 32'h2);
        chk("t5_mv",        32'(mv2),32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_rst_mv",    32'(mv2),  32'h0);
        chk("t5_rst_grant", 32'(g2),   32'h0);
        chk("t5_rst_ready", 32'(rdy2), 32'h0);
        v2 = 2'b11;
        step();
        chk("t5_restart_grant", 32'(g2), 32'h1);
        mr2 = 1'b1;
        step();
        mr2 = 1'b0;
        v2 = 2'b00;
        chk("t5_restart_ready", 32'(rdy2), 32'h1);
        step();

        // 6: NREQ=4, last_grant=1 with requesters 1 and 3 valid -> 3 then 1
        addr4[63:32]   = 32'h1111_0000;
        addr4[127:96]  = 32'h3333_0000;
        v4 = 4'b0010;
        step();
        chk("t6_setup_grant", 32'(g4), 32'h2);
        mr4 = 1'b1;
        step();
        mr4 = 1'b0;
        chk("t6_setup_ready", 32'(rdy4), 32'h2);
        v4 = 4'b1010;
        step();
        step();
        chk("t6_grant3", 32'(g4), 32'h8);
        chk("t6_addr3",  ma4,     32'h3333_0000);
        mr4 = 1'b1;
        step();
        mr4 = 1'b0;
        chk("t6_ready3", 32'(rdy4), 32'h8);
        v4 = 4'b0010;
        step();
        step();
        chk("t6_grant1", 32'(g4), 32'h2);
        chk("t6_addr1",  ma4,     32'h1111_0000);
        mr4 = 1'b1;
        step();
        mr4 = 1'b0;
        v4 = 4'b0000;
        chk("t6_ready1", 32'(rdy4), 32'h2);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
